// File: rtl/ab_client_regfile.sv
// Async-bus client endpoint: CTRL/STATUS/FIFO/SCRATCH register map with a locally filled pop FIFO; `AB_CLIENT_IRQ_EN adds irq_o.
// Ack rises 4 clocks after a request edge and falls 3 clocks after its release; pushes into a full FIFO are dropped and flag OVF.
module ab_client_regfile #(
  parameter int ADDR_BITS  = 5,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 ab_write_req_i,
  input  logic                 ab_read_req_i,
  output logic                 ab_ack_o,
  input  logic [ADDR_BITS-1:0] ab_addr_i,
  inout  wire  [DATA_BITS-1:0] ab_data_io,
  input  logic                 loc_push_i,
  input  logic [DATA_BITS-1:0] loc_data_i,
  output logic                 loc_full_o,
  output logic [DATA_BITS-1:0] ctrl_o,
  output logic                 irq_o
);

  localparam int PTR_BITS = $clog2(FIFO_DEPTH);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] ACK  = 2'd2;
  localparam logic [PTR_BITS:0] PTR_ONE = {{PTR_BITS{1'b0}}, 1'b1};
  localparam logic [PTR_BITS:0] PTR_WRAP = {1'b1, {PTR_BITS{1'b0}}};

  logic [1:0]           state;
  logic                 rd_meta, rd_s, wr_meta, wr_s;
  logic                 op_rd;
  logic [DATA_BITS-1:0] rd_data, rd_value, status;
  logic [DATA_BITS-1:0] ctrl, scratch;
  logic                 ovf;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_BITS:0]    wr_ptr, rd_ptr;
  logic                 fifo_empty, fifo_full;
  logic                 exec_rd, exec_wr, pop, push, ovf_set, ovf_clr;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = ((wr_ptr ^ rd_ptr) == PTR_WRAP);

  // A simultaneous read and write is served as a read only.
  assign exec_rd = (state == EXEC) && rd_s;
  assign exec_wr = (state == EXEC) && wr_s && !rd_s;
  assign pop     = exec_rd && (ab_addr_i == ADDR_BITS'(2)) && !fifo_empty;
  assign push    = loc_push_i && (!fifo_full || pop);
  assign ovf_set = loc_push_i && fifo_full && !pop;
  assign ovf_clr = exec_wr && (ab_addr_i == ADDR_BITS'(1)) && ab_data_io[2];

  always_comb begin
    status    = '0;
    status[0] = !fifo_empty;
    status[1] = fifo_full;
    status[2] = ovf;
    rd_value  = '0;
    case (ab_addr_i)
      ADDR_BITS'(0): rd_value = ctrl;
      ADDR_BITS'(1): rd_value = status;
      ADDR_BITS'(2): rd_value = fifo_empty ? '0 : mem[rd_ptr[PTR_BITS-1:0]];
      ADDR_BITS'(3): rd_value = scratch;
      default:       rd_value = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rd_meta  <= 1'b0;
      rd_s     <= 1'b0;
      wr_meta  <= 1'b0;
      wr_s     <= 1'b0;
      state    <= IDLE;
      ab_ack_o <= 1'b0;
      op_rd    <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_meta <= ab_read_req_i;
      rd_s    <= rd_meta;
      wr_meta <= ab_write_req_i;
      wr_s    <= wr_meta;
      case (state)
        IDLE: if (rd_s || wr_s) state <= EXEC;
        EXEC: begin
          op_rd    <= rd_s;
          rd_data  <= rd_s ? rd_value : '0;
          ab_ack_o <= 1'b1;
          state    <= ACK;
        end
        ACK: if (!rd_s && !wr_s) begin
          ab_ack_o <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ctrl    <= '0;
      scratch <= '0;
      ovf     <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
    end else begin
      if (exec_wr && (ab_addr_i == ADDR_BITS'(0))) ctrl <= ab_data_io;
      if (exec_wr && (ab_addr_i == ADDR_BITS'(3))) scratch <= ab_data_io;
      // A new overflow outranks a clear landing in the same cycle.
      if (ovf_set)      ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr[PTR_BITS-1:0]] <= loc_data_i;
  end

  assign loc_full_o = fifo_full;
  assign ctrl_o     = ctrl;
  // Released as soon as the raw read request drops, without waiting for the synchroniser.
  assign ab_data_io = (state == ACK && op_rd && ab_read_req_i) ? rd_data : 'z;

`ifdef AB_CLIENT_IRQ_EN
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) irq_o <= 1'b0;
    else         irq_o <= (ctrl[0] && !fifo_empty) || (ctrl[1] && ovf);
  end
`else
  assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_ab_client_regfile.sv
// Bench for ab_client_regfile: bus handshake timing, register map, FIFO and overflow rules, reset, irq.
module tb_ab_client_regfile;
  localparam int AB = 5;
  localparam int DB = 8;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_req, rd_req;
  logic          ack;
  logic [AB-1:0] addr;
  wire  [DB-1:0] data_bus;
  logic [DB-1:0] drv_dat;
  logic          drv_en;
  logic          push;
  logic [DB-1:0] push_dat;
  logic          full;
  logic [DB-1:0] ctrl;
  logic          irq;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [DB-1:0] m_ctrl, m_scratch;
  logic          m_ovf;
  logic [DB-1:0] m_q[$];

  assign data_bus = drv_en ? drv_dat : 'z;

  ab_client_regfile #(.ADDR_BITS(AB), .DATA_BITS(DB), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk), .reset_i(rst), .ab_write_req_i(wr_req), .ab_read_req_i(rd_req),
    .ab_ack_o(ack), .ab_addr_i(addr), .ab_data_io(data_bus), .loc_push_i(push),
    .loc_data_i(push_dat), .loc_full_o(full), .ctrl_o(ctrl), .irq_o(irq));

  always #5 clk = ~clk;

  task automatic m_reset();
    m_ctrl = '0; m_scratch = '0; m_ovf = 1'b0; m_q.delete();
  endtask

  task automatic m_read(input int a, output logic [DB-1:0] d);
    case (a)
      0: d = m_ctrl;
      1: d = {5'b0, m_ovf, m_q.size() == DEPTH, m_q.size() != 0};
      2: d = (m_q.size() != 0) ? m_q.pop_front() : 8'h00;
      3: d = m_scratch;
      default: d = 8'h00;
    endcase
  endtask

  task automatic m_write(input int a, input logic [DB-1:0] d);
    if (a == 0) m_ctrl = d;
    if (a == 1 && d[2]) m_ovf = 1'b0;
    if (a == 3) m_scratch = d;
  endtask

  function automatic logic exp_irq();
`ifdef AB_CLIENT_IRQ_EN
    return (m_ctrl[0] && m_q.size() != 0) || (m_ctrl[1] && m_ovf);
`else
    return 1'b0;
`endif
  endfunction

  // One bus access; called #1 after a rising edge. Returns data seen during ack, edge counts, and
  // the bus value read back while the bench drives ~rd just after the read request drops.
  task automatic bus_op(input bit is_rd, input int a, input logic [DB-1:0] wd,
                        output logic [DB-1:0] rd, output int lat_up, output int lat_dn,
                        output logic [DB-1:0] rel);
    addr = AB'(a);
    if (is_rd) rd_req = 1'b1;
    else begin drv_dat = wd; drv_en = 1'b1; wr_req = 1'b1; end
    lat_up = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (ack) begin lat_up = n; break; end
    end
    rd = data_bus;
    rd_req = 1'b0; wr_req = 1'b0; drv_en = 1'b0;
    #1;
    drv_dat = ~rd; drv_en = 1'b1;
    #1;
    rel = data_bus;
    drv_en = 1'b0;
    lat_dn = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (!ack) begin lat_dn = n; break; end
    end
  endtask

  task automatic bus_read(input int a, output logic [DB-1:0] d);
    int u, w; logic [DB-1:0] r;
    bus_op(1'b1, a, 8'h00, d, u, w, r);
  endtask

  task automatic bus_write(input int a, input logic [DB-1:0] d);
    int u, w; logic [DB-1:0] r, x;
    bus_op(1'b0, a, d, x, u, w, r);
    m_write(a, d);
  endtask

  task automatic local_push(input logic [DB-1:0] d);
    push = 1'b1; push_dat = d;
    @(posedge clk); #1;
    push = 1'b0;
    if (m_q.size() == DEPTH) m_ovf = 1'b1;
    else m_q.push_back(d);
  endtask

  task automatic test_reset();
    logic [DB-1:0] v;
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b exp 0", ack); end
    checks++; if (ctrl !== 8'h00) begin errors++; $display("FAIL reset_ctrl got %h exp 00", ctrl); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", irq); end
    drv_dat = 8'h3C; drv_en = 1'b1; #1; v = data_bus; drv_en = 1'b0;
    checks++; if (v !== 8'h3C) begin errors++; $display("FAIL reset_bus_release got %h exp 3c", v); end
    @(posedge clk); #1;
  endtask

  task automatic test_scratch();
    logic [DB-1:0] d, r; int up, dn;
    bus_op(1'b0, 3, 8'hA5, d, up, dn, r);
    m_write(3, 8'hA5);
    checks++; if (up != 4) begin errors++; $display("FAIL wr_ack_latency got %0d exp 4", up); end
    checks++; if (dn != 3) begin errors++; $display("FAIL wr_ack_release got %0d exp 3", dn); end
    bus_op(1'b1, 3, 8'h00, d, up, dn, r);
    checks++; if (up != 4) begin errors++; $display("FAIL rd_ack_latency got %0d exp 4", up); end
    checks++; if (d !== 8'hA5) begin errors++; $display("FAIL scratch_read got %h exp a5", d); end
    checks++; if (r !== 8'h5A) begin errors++; $display("FAIL rd_release got %h exp 5a", r); end
    checks++; if (dn != 3) begin errors++; $display("FAIL rd_ack_release got %0d exp 3", dn); end
  endtask

  task automatic test_fifo_order();
    logic [DB-1:0] d, e;
    local_push(8'h11); local_push(8'h22); local_push(8'h33);
    for (int i = 0; i < 4; i++) begin
      bus_read(2, d); m_read(2, e);
      checks++; if (d !== e) begin errors++; $display("FAIL fifo_pop%0d got %h exp %h", i, d, e); end
    end
    bus_read(1, d); m_read(1, e);
    checks++; if (d !== e) begin errors++; $display("FAIL status_empty got %h exp %h", d, e); end
  endtask

  task automatic test_overflow();
    logic [DB-1:0] d, e;
    for (int i = 0; i <= DEPTH; i++) local_push(DB'(8'h40 + i));
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL ovf_full got %b exp 1", full); end
    bus_read(1, d); m_read(1, e);
    checks++; if (d !== e) begin errors++; $display("FAIL status_ovf got %h exp %h", d, e); end
    bus_write(1, 8'h04);
    bus_read(1, d); m_read(1, e);
    checks++; if (d !== e) begin errors++; $display("FAIL status_clr got %h exp %h", d, e); end
  endtask

  task automatic test_push_pop_full();
    logic [DB-1:0] d, e;
    addr = AB'(2); rd_req = 1'b1;
    repeat (3) @(posedge clk);
    #1; push = 1'b1; push_dat = 8'h99;
    @(posedge clk); #1; push = 1'b0;
    d = data_bus;
    m_read(2, e); m_q.push_back(8'h99);
    checks++; if (d !== e) begin errors++; $display("FAIL pp_read got %h exp %h", d, e); end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL pp_full got %b exp 1", full); end
    rd_req = 1'b0;
    for (int n = 0; n < 20 && ack; n++) begin @(posedge clk); #1; end
    bus_read(1, d); m_read(1, e);
    checks++; if (d !== e) begin errors++; $display("FAIL pp_status got %h exp %h", d, e); end
    for (int i = 0; i < DEPTH; i++) begin
      bus_read(2, d); m_read(2, e);
      checks++; if (d !== e) begin errors++; $display("FAIL drain%0d got %h exp %h", i, d, e); end
    end
  endtask

  task automatic test_irq();
    bus_write(0, 8'h01);
    local_push(8'h77);
    @(posedge clk); #1;
    checks++; if (irq !== exp_irq()) begin errors++; $display("FAIL irq_set got %b exp %b", irq, exp_irq()); end
    begin logic [DB-1:0] d, e; bus_read(2, d); m_read(2, e); end
    checks++; if (irq !== exp_irq()) begin errors++; $display("FAIL irq_clr got %b exp %b", irq, exp_irq()); end
  endtask

  task automatic test_random();
    logic [DB-1:0] d, e; int a, op;
    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 3);
      if (op == 0) begin
        for (int k = $urandom_range(1, 3); k > 0; k--) local_push(DB'($urandom));
        @(posedge clk); #1;
      end else if (op == 1) begin
        a = $urandom_range(0, 7);
        bus_write(a, DB'($urandom));
      end else begin
        a = (op == 3) ? 2 : $urandom_range(0, 7);
        bus_read(a, d); m_read(a, e);
        checks++; if (d !== e) begin errors++; $display("FAIL rnd_read%0d a=%0d got %h exp %h", i, a, d, e); end
      end
      checks++;
      if (ctrl !== m_ctrl || full !== (m_q.size() == DEPTH) || irq !== exp_irq()) begin
        errors++;
        $display("FAIL rnd_state%0d got ctrl=%h full=%b irq=%b exp ctrl=%h full=%b irq=%b",
                 i, ctrl, full, irq, m_ctrl, m_q.size() == DEPTH, exp_irq());
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [DB-1:0] v; int up;
    bus_write(0, 8'h5A);
    local_push(8'h21); local_push(8'h42);
    addr = AB'(0); rd_req = 1'b1;
    for (int n = 0; n < 20 && !ack; n++) begin @(posedge clk); #1; end
    #2; rst = 1'b1; #1;
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rst_mid_ack got %b exp 0", ack); end
    drv_dat = 8'hC3; drv_en = 1'b1; #1; v = data_bus; drv_en = 1'b0;
    checks++; if (v !== 8'hC3) begin errors++; $display("FAIL rst_mid_bus got %h exp c3", v); end
    checks++; if (ctrl !== 8'h00) begin errors++; $display("FAIL rst_mid_ctrl got %h exp 00", ctrl); end
    m_reset();
    @(posedge clk); #1; rst = 1'b0;
    up = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (ack) begin up = n; break; end
    end
    checks++; if (up != 4) begin errors++; $display("FAIL rst_reserve_latency got %0d exp 4", up); end
    v = data_bus;
    checks++; if (v !== m_ctrl) begin errors++; $display("FAIL rst_reserve_data got %h exp %h", v, m_ctrl); end
    rd_req = 1'b0;
    for (int n = 0; n < 20 && ack; n++) begin @(posedge clk); #1; end
    begin logic [DB-1:0] d, e; bus_read(1, d); m_read(1, e);
      checks++; if (d !== e) begin errors++; $display("FAIL rst_status got %h exp %h", d, e); end
    end
  endtask

  initial begin
    rst = 1'b1; wr_req = 1'b0; rd_req = 1'b0; addr = '0; drv_dat = '0; drv_en = 1'b0;
    push = 1'b0; push_dat = '0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    test_scratch();
    test_fifo_order();
    test_overflow();
    test_push_pop_full();
    test_irq();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    errors++;
    $display("FAIL watchdog expired at %0t", $time);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end
endmodule
